// File: rtl/sum_tx_sequencer.sv
// ----------------------------------------------------------------------------
// sum_tx_sequencer
//   Front-end controller for the operand-latch / 4-bit adder / UART-TX chain.
//   Debounces three raw active-low buttons and strobes the operand latch save
//   lines. On a send request it snapshots the 5-bit sum, formats it as two
//   ASCII decimal digits followed by CR LF, and feeds the UART one byte at a
//   time through its en/busy handshake.
//
// Ports
//   clk          in   system clock, rising edge
//   reset_n      in   synchronous active-low reset
//   btn_a_n      in   raw button, low = capture operand A
//   btn_b_n      in   raw button, low = capture operand B
//   btn_send_n   in   raw button, low = transmit current sum
//   sum_in       in   [4:0] adder result
//   uartbusy     in   UART transmitter busy
//   save_a_n     out  latch A save strobe, active low, one cycle
//   save_b_n     out  latch B save strobe, active low, one cycle
//   uart_tx_en   out  one-cycle byte-start strobe
//   uart_tx_data out  [7:0] byte presented to the UART, held through the byte
//   seq_busy     out  high while the FSM is not IDLE
//   seq_done     out  one-cycle pulse after the 4th byte completes
//   err_timeout  out  sticky handshake-timeout flag, cleared at next send
//   dbg_state    out  [3:0] current FSM state encoding
//
// UART handshake: the sequencer only raises uart_tx_en while uartbusy is low
// and uart_tx_data already holds the byte. It then expects uartbusy to rise
// within BUSY_TIMEOUT+1 cycles and treats its fall as byte completion; the
// data register is not touched again until that fall.
// ----------------------------------------------------------------------------
module sum_tx_sequencer #(
  parameter int DEBOUNCE_CYCLES = 1000,
  parameter int SETTLE_CYCLES   = 2,
  parameter int BUSY_TIMEOUT    = 64,
  parameter bit AUTO_SEND       = 1'b0
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       btn_a_n,
  input  logic       btn_b_n,
  input  logic       btn_send_n,
  input  logic [4:0] sum_in,
  input  logic       uartbusy,
  output logic       save_a_n,
  output logic       save_b_n,
  output logic       uart_tx_en,
  output logic [7:0] uart_tx_data,
  output logic       seq_busy,
  output logic       seq_done,
  output logic       err_timeout,
  output logic [3:0] dbg_state
);

  typedef enum logic [3:0] {
    IDLE      = 4'd0,
    SAVE_A    = 4'd1,
    SAVE_B    = 4'd2,
    SETTLE    = 4'd3,
    SNAP      = 4'd4,
    WAIT_IDLE = 4'd5,
    STROBE    = 4'd6,
    WAIT_HI   = 4'd7,
    WAIT_LO   = 4'd8,
    DONE      = 4'd9
  } state_t;

  localparam int DBW     = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int CNT_MAX = (BUSY_TIMEOUT > SETTLE_CYCLES) ? BUSY_TIMEOUT : SETTLE_CYCLES;
  localparam int CNTW    = $clog2(CNT_MAX + 2);

  // --------------------------------------------------------------------------
  // Debouncers: bit 0 = A, bit 1 = B, bit 2 = send.
  // A level is accepted once the synchronized input has differed from the
  // accepted level for DEBOUNCE_CYCLES consecutive samples. evt pulses for one
  // cycle on an accepted 1->0 change, so one physical press gives one event.
  // --------------------------------------------------------------------------
  logic [2:0]     raw;
  logic [2:0]     sync1;
  logic [2:0]     sync2;
  logic [2:0]     stable;
  logic [2:0]     evt;
  logic [DBW-1:0] db_cnt [3];

  assign raw = {btn_send_n, btn_b_n, btn_a_n};

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sync1  <= 3'b111;
      sync2  <= 3'b111;
      stable <= 3'b111;
      evt    <= 3'b000;
      for (int i = 0; i < 3; i++) db_cnt[i] <= '0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      evt   <= 3'b000;
      for (int i = 0; i < 3; i++) begin
        if (sync2[i] == stable[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DBW'(DEBOUNCE_CYCLES - 1)) begin
          db_cnt[i] <= '0;
          stable[i] <= sync2[i];
          evt[i]    <= ~sync2[i];
        end else begin
          db_cnt[i] <= db_cnt[i] + 1'b1;
        end
      end
    end
  end

  // --------------------------------------------------------------------------
  // FSM and datapath registers
  // --------------------------------------------------------------------------
  state_t          state;
  state_t          state_next;
  logic            pend_b;
  logic            pend_send;
  logic [CNTW-1:0] cnt;
  logic [1:0]      idx;
  logic [1:0]      tens_r;
  logic [4:0]      ones_r;
  logic [1:0]      tens_c;
  logic [4:0]      ones_c;
  logic [7:0]      byte_sel;

  // Decimal split of the live sum; only registered in SNAP.
  always_comb begin
    tens_c = 2'd0;
    ones_c = sum_in;
    if (sum_in >= 5'd30) begin
      tens_c = 2'd3;
      ones_c = sum_in - 5'd30;
    end else if (sum_in >= 5'd20) begin
      tens_c = 2'd2;
      ones_c = sum_in - 5'd20;
    end else if (sum_in >= 5'd10) begin
      tens_c = 2'd1;
      ones_c = sum_in - 5'd10;
    end
  end

  always_comb begin
    byte_sel = 8'h0A;
    case (idx)
      2'd0:    byte_sel = 8'h30 + {6'd0, tens_r};
      2'd1:    byte_sel = 8'h30 + {3'd0, ones_r};
      2'd2:    byte_sel = 8'h0D;
      default: byte_sel = 8'h0A;
    endcase
  end

  always_comb begin
    state_next = state;
    save_a_n   = 1'b1;
    save_b_n   = 1'b1;
    uart_tx_en = 1'b0;
    seq_done   = 1'b0;
    case (state)
      IDLE: begin
        if (evt[0])      state_next = SAVE_A;
        else if (evt[1]) state_next = SAVE_B;
        else if (evt[2]) state_next = SETTLE;
      end
      SAVE_A: begin
        save_a_n = 1'b0;
        if (pend_b)         state_next = SAVE_B;
        else if (pend_send) state_next = SETTLE;
        else                state_next = IDLE;
      end
      SAVE_B: begin
        save_b_n   = 1'b0;
        state_next = pend_send ? SETTLE : IDLE;
      end
      SETTLE: begin
        if (int'(cnt) + 1 >= SETTLE_CYCLES) state_next = SNAP;
      end
      SNAP: state_next = WAIT_IDLE;
      WAIT_IDLE: begin
        if (!uartbusy) state_next = STROBE;
      end
      STROBE: begin
        uart_tx_en = 1'b1;
        state_next = WAIT_HI;
      end
      WAIT_HI: begin
        // cnt is 0 on the first WAIT_HI cycle, so the abort happens on the
        // (BUSY_TIMEOUT+1)-th cycle without busy.
        if (uartbusy)                        state_next = WAIT_LO;
        else if (int'(cnt) >= BUSY_TIMEOUT)  state_next = IDLE;
      end
      WAIT_LO: begin
        if (!uartbusy) state_next = (idx == 2'd3) ? DONE : WAIT_IDLE;
      end
      DONE: begin
        seq_done   = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state        <= IDLE;
      pend_b       <= 1'b0;
      pend_send    <= 1'b0;
      cnt          <= '0;
      idx          <= 2'd0;
      tens_r       <= 2'd0;
      ones_r       <= 5'd0;
      uart_tx_data <= 8'h00;
      err_timeout  <= 1'b0;
    end else begin
      state <= state_next;

      // Per-state cycle counter, restarted on every state change.
      if (state_next != state) cnt <= '0;
      else if (cnt != '1)      cnt <= cnt + 1'b1;

      // Remember what must follow the A strobe when several events coincide.
      if (state == IDLE) begin
        pend_b    <= evt[0] & evt[1];
        pend_send <= (evt[0] | evt[1]) & (evt[2] | (AUTO_SEND & evt[1]));
      end

      if (state_next == SETTLE && state != SETTLE) err_timeout <= 1'b0;
      if (state == WAIT_HI && state_next == IDLE)  err_timeout <= 1'b1;

      if (state == SNAP) begin
        tens_r <= tens_c;
        ones_r <= ones_c;
        idx    <= 2'd0;
      end

      if (state == WAIT_IDLE && !uartbusy) uart_tx_data <= byte_sel;

      if (state == WAIT_LO && !uartbusy && idx != 2'd3) idx <= idx + 2'd1;
    end
  end

  assign seq_busy  = (state != IDLE);
  assign dbg_state = state;

endmodule

// File: tb/tb_sum_tx_sequencer.sv
// ----------------------------------------------------------------------------
// tb_sum_tx_sequencer
//   Directed bench for sum_tx_sequencer. A negedge process acts as the UART
//   (raises busy two cycles after uart_tx_en for busy_len cycles, or never
//   when uart_dead is set), records the bytes sent, and counts strobes and
//   pulses. Each test task drives buttons and checks against hand-computed
//   values.
// ----------------------------------------------------------------------------
module tb_sum_tx_sequencer;

  localparam int DEB      = 1000;
  localparam logic [3:0] ST_WAIT_LO = 4'd8;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       btn_a_n;
  logic       btn_b_n;
  logic       btn_send_n;
  logic [4:0] sum_in;
  logic       uartbusy = 1'b0;
  logic       save_a_n;
  logic       save_b_n;
  logic       uart_tx_en;
  logic [7:0] uart_tx_data;
  logic       seq_busy;
  logic       seq_done;
  logic       err_timeout;
  logic [3:0] dbg_state;

  int n_checks = 0;
  int n_fail   = 0;

  // monitor / UART model state
  int cyc = 0;
  int ph = 0;
  int busy_len = 10;
  bit uart_dead = 1'b0;
  int a_pulses = 0, a_low = 0, a_cyc = 0;
  int b_pulses = 0, b_low = 0, b_cyc = 0;
  int tx_cnt = 0, tx_cyc = 0;
  int done_cnt = 0;
  int err_cyc = 0;
  logic prev_a = 1'b1, prev_b = 1'b1, prev_err = 1'b0;
  logic [7:0] rx_q[$];
  logic [7:0] exp_q[$];

  sum_tx_sequencer #(
    .DEBOUNCE_CYCLES(DEB),
    .SETTLE_CYCLES(2),
    .BUSY_TIMEOUT(64),
    .AUTO_SEND(1'b0)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .btn_a_n(btn_a_n),
    .btn_b_n(btn_b_n),
    .btn_send_n(btn_send_n),
    .sum_in(sum_in),
    .uartbusy(uartbusy),
    .save_a_n(save_a_n),
    .save_b_n(save_b_n),
    .uart_tx_en(uart_tx_en),
    .uart_tx_data(uart_tx_data),
    .seq_busy(seq_busy),
    .seq_done(seq_done),
    .err_timeout(err_timeout),
    .dbg_state(dbg_state)
  );

  // -------------------------------------------------------------- clock/reset
  always #5 clk = ~clk;

  // ---------------------------------------------- monitor and UART responder
  always @(negedge clk) begin
    cyc = cyc + 1;
    if (!save_a_n) begin
      a_low = a_low + 1;
      if (prev_a) begin a_pulses = a_pulses + 1; a_cyc = cyc; end
    end
    prev_a = save_a_n;
    if (!save_b_n) begin
      b_low = b_low + 1;
      if (prev_b) begin b_pulses = b_pulses + 1; b_cyc = cyc; end
    end
    prev_b = save_b_n;
    if (err_timeout && !prev_err) err_cyc = cyc;
    prev_err = err_timeout;
    if (seq_done) done_cnt = done_cnt + 1;
    if (uart_tx_en) begin
      tx_cnt = tx_cnt + 1;
      tx_cyc = cyc;
      rx_q.push_back(uart_tx_data);
      ph = uart_dead ? 0 : 1;
    end else if (ph > 0) begin
      ph = (ph >= busy_len + 2) ? 0 : ph + 1;
    end
    uartbusy = (ph >= 3);
  end

  // ------------------------------------------------------------ driver tasks
  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // which: 0 = A, 1 = B, 2 = send, 3 = A and B together
  task automatic hold_low(input int which, input int cycles);
    @(negedge clk);
    if (which == 0 || which == 3) btn_a_n = 1'b0;
    if (which == 1 || which == 3) btn_b_n = 1'b0;
    if (which == 2)               btn_send_n = 1'b0;
    wait_cycles(cycles);
    btn_a_n    = 1'b1;
    btn_b_n    = 1'b1;
    btn_send_n = 1'b1;
  endtask

  // ------------------------------------------------------------------- tests
  task automatic test_reset;
    reset_n = 1'b0;
    wait_cycles(3);
    n_checks += 8;
    if (save_a_n !== 1'b1)     begin n_fail++; $display("FAIL reset save_a_n got %b want 1", save_a_n); end
    if (save_b_n !== 1'b1)     begin n_fail++; $display("FAIL reset save_b_n got %b want 1", save_b_n); end
    if (uart_tx_en !== 1'b0)   begin n_fail++; $display("FAIL reset uart_tx_en got %b want 0", uart_tx_en); end
    if (uart_tx_data !== 8'h0) begin n_fail++; $display("FAIL reset uart_tx_data got %h want 00", uart_tx_data); end
    if (seq_busy !== 1'b0)     begin n_fail++; $display("FAIL reset seq_busy got %b want 0", seq_busy); end
    if (seq_done !== 1'b0)     begin n_fail++; $display("FAIL reset seq_done got %b want 0", seq_done); end
    if (err_timeout !== 1'b0)  begin n_fail++; $display("FAIL reset err_timeout got %b want 0", err_timeout); end
    if (dbg_state !== 4'd0)    begin n_fail++; $display("FAIL reset state got %0d want 0", dbg_state); end
    reset_n = 1'b1;
    wait_cycles(2);
  endtask

  task automatic test_press_a;
    int p0, l0, c0;
    p0 = a_pulses; l0 = a_low; c0 = cyc + 1;
    hold_low(0, 1200);
    wait_cycles(DEB + 50);
    n_checks += 4;
    if (a_pulses - p0 !== 1) begin n_fail++; $display("FAIL press_a pulses got %0d want 1", a_pulses - p0); end
    if (a_low - l0 !== 1)    begin n_fail++; $display("FAIL press_a low_cycles got %0d want 1", a_low - l0); end
    if (a_cyc - c0 < DEB || a_cyc - c0 > DEB + 10)
      begin n_fail++; $display("FAIL press_a latency got %0d want %0d..%0d", a_cyc - c0, DEB, DEB + 10); end
    if (b_pulses !== 0)      begin n_fail++; $display("FAIL press_a b_pulses got %0d want 0", b_pulses); end
  endtask

  task automatic test_glitch;
    int p0;
    p0 = a_pulses;
    hold_low(0, 500);
    wait_cycles(DEB + 50);
    n_checks++;
    if (a_pulses - p0 !== 0) begin n_fail++; $display("FAIL glitch pulses got %0d want 0", a_pulses - p0); end
  endtask

  task automatic test_long_press;
    int p0, l0;
    p0 = a_pulses; l0 = a_low;
    hold_low(0, 10000);
    wait_cycles(DEB + 50);
    n_checks += 2;
    if (a_pulses - p0 !== 1) begin n_fail++; $display("FAIL long_press pulses got %0d want 1", a_pulses - p0); end
    if (a_low - l0 !== 1)    begin n_fail++; $display("FAIL long_press low_cycles got %0d want 1", a_low - l0); end
  endtask

  task automatic test_a_b_same;
    int pa, pb, lb;
    pa = a_pulses; pb = b_pulses; lb = b_low;
    hold_low(3, 1200);
    wait_cycles(DEB + 50);
    n_checks += 4;
    if (a_pulses - pa !== 1) begin n_fail++; $display("FAIL ab_same a_pulses got %0d want 1", a_pulses - pa); end
    if (b_pulses - pb !== 1) begin n_fail++; $display("FAIL ab_same b_pulses got %0d want 1", b_pulses - pb); end
    if (b_low - lb !== 1)    begin n_fail++; $display("FAIL ab_same b_low got %0d want 1", b_low - lb); end
    if (b_cyc - a_cyc !== 1) begin n_fail++; $display("FAIL ab_same order got b-a=%0d want 1", b_cyc - a_cyc); end
  endtask

  // Sends with the given sum; after the first byte is strobed the sum input is
  // changed to prove the snapshot is held for the whole message.
  task automatic test_send(input logic [4:0] s, input logic [7:0] d0, input logic [7:0] d1,
                           input string name);
    int t0, dn0, pa0, k;
    logic [7:0] got;
    rx_q = {};
    exp_q = {};
    exp_q.push_back(d0);
    exp_q.push_back(d1);
    exp_q.push_back(8'h0D);
    exp_q.push_back(8'h0A);
    t0 = tx_cnt; dn0 = done_cnt; pa0 = a_pulses;
    sum_in = s;
    @(negedge clk);
    btn_send_n = 1'b0;
    k = 0;
    while (k < 1100) begin
      @(negedge clk);
      k++;
      if (tx_cnt != t0) sum_in = ~s;
    end
    btn_send_n = 1'b1;
    wait_cycles(DEB + 50);
    n_checks += 6;
    if (tx_cnt - t0 !== 4)    begin n_fail++; $display("FAIL %s tx_en_count got %0d want 4", name, tx_cnt - t0); end
    if (done_cnt - dn0 !== 1) begin n_fail++; $display("FAIL %s seq_done got %0d want 1", name, done_cnt - dn0); end
    if (err_timeout !== 1'b0) begin n_fail++; $display("FAIL %s err_timeout got %b want 0", name, err_timeout); end
    if (seq_busy !== 1'b0)    begin n_fail++; $display("FAIL %s seq_busy got %b want 0", name, seq_busy); end
    if (a_pulses - pa0 !== 0) begin n_fail++; $display("FAIL %s save_a got %0d want 0", name, a_pulses - pa0); end
    if (rx_q.size() !== 4)    begin n_fail++; $display("FAIL %s byte_count got %0d want 4", name, rx_q.size()); end
    while (exp_q.size() > 0) begin
      n_checks++;
      if (rx_q.size() == 0) begin
        n_fail++; $display("FAIL %s byte missing want %h", name, exp_q.pop_front());
      end else begin
        got = rx_q.pop_front();
        if (got !== exp_q[0]) begin n_fail++; $display("FAIL %s byte got %h want %h", name, got, exp_q[0]); end
        void'(exp_q.pop_front());
      end
    end
  endtask

  task automatic test_timeout;
    int t0, dn0;
    uart_dead = 1'b1;
    t0 = tx_cnt; dn0 = done_cnt;
    hold_low(2, 1100);
    wait_cycles(DEB + 50);
    n_checks += 5;
    if (tx_cnt - t0 !== 1)    begin n_fail++; $display("FAIL timeout tx_en_count got %0d want 1", tx_cnt - t0); end
    if (err_timeout !== 1'b1) begin n_fail++; $display("FAIL timeout err_timeout got %b want 1", err_timeout); end
    if (err_cyc - tx_cyc < 65 || err_cyc - tx_cyc > 66)
      begin n_fail++; $display("FAIL timeout delay got %0d want 65..66", err_cyc - tx_cyc); end
    if (seq_busy !== 1'b0)    begin n_fail++; $display("FAIL timeout seq_busy got %b want 0", seq_busy); end
    if (done_cnt - dn0 !== 0) begin n_fail++; $display("FAIL timeout seq_done got %0d want 0", done_cnt - dn0); end
    uart_dead = 1'b0;
  endtask

  // A pressed while a slow message is in flight must produce no strobe.
  task automatic test_press_while_busy;
    int pa0, dn0;
    busy_len = 400;
    pa0 = a_pulses; dn0 = done_cnt;
    sum_in = 5'd19;
    hold_low(2, 1100);
    n_checks++;
    if (seq_busy !== 1'b1) begin n_fail++; $display("FAIL busy_press seq_busy got %b want 1", seq_busy); end
    hold_low(0, 1100);
    wait_cycles(2 * DEB);
    n_checks += 3;
    if (a_pulses - pa0 !== 0) begin n_fail++; $display("FAIL busy_press save_a got %0d want 0", a_pulses - pa0); end
    if (done_cnt - dn0 !== 1) begin n_fail++; $display("FAIL busy_press seq_done got %0d want 1", done_cnt - dn0); end
    if (seq_busy !== 1'b0)    begin n_fail++; $display("FAIL busy_press idle got %b want 0", seq_busy); end
  endtask

  task automatic test_reset_wait_lo;
    int k;
    busy_len = 400;
    sum_in = 5'd10;
    hold_low(2, 1100);
    k = 0;
    while (dbg_state !== ST_WAIT_LO && k < 2000) begin @(negedge clk); k++; end
    n_checks++;
    if (dbg_state !== ST_WAIT_LO) begin n_fail++; $display("FAIL reset_wait_lo reach got %0d want 8", dbg_state); end
    reset_n = 1'b0;
    @(negedge clk);
    n_checks += 6;
    if (dbg_state !== 4'd0)    begin n_fail++; $display("FAIL reset_wait_lo state got %0d want 0", dbg_state); end
    if (seq_busy !== 1'b0)     begin n_fail++; $display("FAIL reset_wait_lo seq_busy got %b want 0", seq_busy); end
    if (uart_tx_data !== 8'h0) begin n_fail++; $display("FAIL reset_wait_lo data got %h want 00", uart_tx_data); end
    if (uart_tx_en !== 1'b0)   begin n_fail++; $display("FAIL reset_wait_lo tx_en got %b want 0", uart_tx_en); end
    if (err_timeout !== 1'b0)  begin n_fail++; $display("FAIL reset_wait_lo err got %b want 0", err_timeout); end
    if (save_a_n !== 1'b1 || save_b_n !== 1'b1)
      begin n_fail++; $display("FAIL reset_wait_lo save got %b%b want 11", save_a_n, save_b_n); end
    reset_n = 1'b1;
    wait_cycles(500);
    busy_len = 10;
  endtask

  // -------------------------------------------------------------- main flow
  initial begin
    reset_n    = 1'b0;
    btn_a_n    = 1'b1;
    btn_b_n    = 1'b1;
    btn_send_n = 1'b1;
    sum_in     = 5'd0;
    test_reset;
    test_press_a;
    test_glitch;
    test_long_press;
    test_a_b_same;
    test_send(5'd27, 8'h32, 8'h37, "send_27");
    test_send(5'd0,  8'h30, 8'h30, "send_0");
    test_send(5'd31, 8'h33, 8'h31, "send_31");
    test_send(5'd10, 8'h31, 8'h30, "send_10");
    test_timeout;
    test_send(5'd29, 8'h32, 8'h39, "send_after_timeout");
    test_press_while_busy;
    test_reset_wait_lo;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Absolute watchdog so the run always ends.
  initial begin
    #2000000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
